uart_tx_desc_scheduler: RTL and testbench

Descriptor scheduler that sequences the UART TX buffer autoreader. Host logic queues transfer descriptors (start address, address increment, bytes per line, line count). The block launches them one at a time into the autoreader's `load_begin` / config inputs and tracks each transfer to completion, meaning all lines requested and the TX FIFO drained. It then raises done/interrupt status.

---
 rtl/uart_tx_desc_scheduler_if.sv | 26 ++
 rtl/uart_tx_desc_scheduler.sv | 152 +++++++++++++++
 tb/tb_uart_tx_desc_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_desc_scheduler_if.sv
// Descriptor channel between host logic and uart_tx_desc_scheduler.
//   desc_valid      host offers a descriptor
//   desc_ready      scheduler accepts on desc_valid & desc_ready
//   desc_start_addr first memory line address
//   desc_addr_inc   address step per line
//   desc_bpl        log2 bytes per line
//   desc_lines      lines to copy (0 is rejected)
// master = host side, slave = scheduler side.
interface uart_tx_desc_scheduler_if;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_start_addr;
  logic [3:0]  desc_addr_inc;
  logic [1:0]  desc_bpl;
  logic [3:0]  desc_lines;

  modport master (
    output desc_valid, desc_start_addr, desc_addr_inc, desc_bpl, desc_lines,
    input  desc_ready
  );

  modport slave (
    input  desc_valid, desc_start_addr, desc_addr_inc, desc_bpl, desc_lines,
    output desc_ready
  );
endinterface

// File: rtl/uart_tx_desc_scheduler.sv
// Descriptor scheduler for the UART TX buffer autoreader. Queues host
// descriptors, launches them one at a time into the autoreader and tracks
// each transfer until all lines were requested and the TX FIFO drained.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   desc                descriptor channel (slave modport)
//   enable              permit launching new descriptors
//   abort               flush pending queue (in-flight transfer completes)
//   irq_clr             clear sticky irq
//   load_begin          one-cycle start pulse to the autoreader
//   start_addr,addr_inc autoreader config, held until the next launch
//   data_struct         {lines, 1'b0, bpl}
//   rdr_mem_read_req    autoreader line-request pulse
//   rdr_fifo_empty      autoreader FIFO empty
//   busy                transfer in progress
//   queue_count         pending descriptors
//   done_pulse          one cycle per completed descriptor
//   err_pulse           one cycle per rejected (zero-line) descriptor
//   irq                 sticky, set by done_pulse/err_pulse
module uart_tx_desc_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_tx_desc_scheduler_if.slave desc,
  input  logic                    enable,
  input  logic                    abort,
  input  logic                    irq_clr,
  output logic                    load_begin,
  output logic [15:0]             start_addr,
  output logic [3:0]              addr_inc,
  output logic [6:0]              data_struct,
  input  logic                    rdr_mem_read_req,
  input  logic                    rdr_fifo_empty,
  output logic                    busy,
  output logic [CW-1:0]           queue_count,
  output logic                    done_pulse,
  output logic                    err_pulse,
  output logic                    irq
);
  localparam int unsigned IW = CW - 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, SETTLE, DRAIN} state_t;

  state_t        state;
  logic [25:0]   q_mem [DEPTH];
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic [3:0]    line_cnt;
  logic [3:0]    settle_cnt;
  logic          hs;
  logic          push;
  logic          pop;
  logic [25:0]   head;

  assign desc.desc_ready = !rst && !abort && (queue_count < CW'(DEPTH));

  // busy stays high in the IDLE cycle carrying done_pulse, which keeps the
  // autoreader one full idle cycle before the next load_begin.
  always_comb begin
    hs   = desc.desc_valid && desc.desc_ready;
    push = hs && (desc.desc_lines != '0);
    pop  = (state == IDLE) && !busy && enable && (queue_count != '0) && !abort;
    head = q_mem[rptr[IW-1:0]];
  end

  // entry layout: {addr[15:0], inc[3:0], bpl[1:0], lines[3:0]}
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wptr[IW-1:0]] <= {desc.desc_start_addr, desc.desc_addr_inc,
                              desc.desc_bpl, desc.desc_lines};
    end
  end

  // abort never coincides with push because desc_ready is low during abort
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      queue_count <= '0;
      err_pulse   <= 1'b0;
    end else begin
      err_pulse <= hs && (desc.desc_lines == '0);
      if (push) wptr <= wptr + CW'(1);
      if (abort) begin
        rptr        <= wptr;
        queue_count <= '0;
      end else begin
        if (pop) rptr <= rptr + CW'(1);
        if (push && !pop)      queue_count <= queue_count + CW'(1);
        else if (pop && !push) queue_count <= queue_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      load_begin  <= 1'b0;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      irq         <= 1'b0;
      start_addr  <= '0;
      addr_inc    <= '0;
      data_struct <= '0;
      line_cnt    <= '0;
      settle_cnt  <= '0;
    end else begin
      load_begin <= 1'b0;
      done_pulse <= 1'b0;
      irq        <= done_pulse || err_pulse || (irq && !irq_clr);
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (pop) begin
            start_addr  <= head[25:10];
            addr_inc    <= head[9:6];
            data_struct <= {head[3:0], 1'b0, head[5:4]};
            load_begin  <= 1'b1;
            busy        <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          line_cnt <= rdr_mem_read_req ? 4'd1 : 4'd0;
          state    <= RUN;
        end
        RUN: begin
          if (line_cnt == data_struct[6:3]) begin
            // covers the byte writes trailing the last line request
            settle_cnt <= (4'd1 << data_struct[1:0]) + 4'd2;
            state      <= SETTLE;
          end else if (rdr_mem_read_req) begin
            line_cnt <= line_cnt + 4'd1;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) state <= DRAIN;
        end
        DRAIN: begin
          if (rdr_fifo_empty) begin
            done_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_desc_scheduler.sv
// Scoreboard bench for uart_tx_desc_scheduler: directed scenarios followed by
// random descriptors, with a cycle-level autoreader emulator.
module tb_uart_tx_desc_scheduler;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, abort, irq_clr;
  logic        load_begin;
  logic [15:0] start_addr;
  logic [3:0]  addr_inc;
  logic [6:0]  data_struct;
  logic        rdr_mem_read_req, rdr_fifo_empty;
  logic        busy;
  logic [CW-1:0] queue_count;
  logic        done_pulse, err_pulse, irq;

  uart_tx_desc_scheduler_if dif ();

  uart_tx_desc_scheduler #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .desc(dif),
    .enable(enable), .abort(abort), .irq_clr(irq_clr),
    .load_begin(load_begin), .start_addr(start_addr), .addr_inc(addr_inc),
    .data_struct(data_struct),
    .rdr_mem_read_req(rdr_mem_read_req), .rdr_fifo_empty(rdr_fifo_empty),
    .busy(busy), .queue_count(queue_count),
    .done_pulse(done_pulse), .err_pulse(err_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  inc;
    logic [1:0]  bpl;
    logic [3:0]  lines;
    int          acc;
  } desc_t;

  desc_t       mq[$];
  int          done_q[$];
  int          err_q[$];
  logic [26:0] cfg_e;
  bit          inflight, irq_e;
  int          last_done, en_low;
  int          ar_lines, ar_bpl;
  bit          slow_mode, drain_mode;
  event        launched;
  int          checks = 0;
  int          passes = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
  endfunction

  // Reference model / monitor, sampled on the falling edge.
  initial begin : monitor
    bit    prev_rst;
    bit    de, ee;
    int    exp_l;
    desc_t e;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ready_in_reset", 64'(dif.desc_ready), 64'(0));
        if (prev_rst)
          chk("reset_outputs", 64'({load_begin, busy, done_pulse, err_pulse, irq,
              queue_count, start_addr, addr_inc, data_struct}), 64'(0));
        mq.delete(); done_q.delete(); err_q.delete();
        inflight = 1'b0; irq_e = 1'b0; cfg_e = '0;
        last_done = -100; en_low = -100;
        prev_rst = 1'b1;
      end else begin
        prev_rst = 1'b0;
        de = (done_q.size() != 0) && (done_q[0] == cyc);
        if (de) void'(done_q.pop_front());
        chk("done_pulse", 64'(done_pulse), 64'(de));
        ee = (err_q.size() != 0) && (err_q[0] == cyc);
        if (ee) void'(err_q.pop_front());
        chk("err_pulse", 64'(err_pulse), 64'(ee));
        if (load_begin) begin
          chk("launch_expected", 64'(mq.size() != 0), 64'(1));
          chk("launch_while_busy", 64'(inflight), 64'(0));
          if (mq.size() != 0) begin
            e = mq.pop_front();
            exp_l = e.acc + 2;
            if (last_done + 2 > exp_l) exp_l = last_done + 2;
            if (en_low + 2 > exp_l)    exp_l = en_low + 2;
            chk("launch_cycle", 64'(cyc), 64'(exp_l));
            cfg_e    = {e.addr, e.inc, e.lines, 1'b0, e.bpl};
            ar_lines = int'(e.lines);
            ar_bpl   = int'(e.bpl);
            inflight = 1'b1;
            ->launched;
          end
        end
        chk("cfg_regs", 64'({start_addr, addr_inc, data_struct}), 64'(cfg_e));
        chk("busy", 64'(busy), 64'(inflight));
        if (de) begin
          inflight  = 1'b0;
          last_done = cyc;
        end
        chk("queue_count", 64'(queue_count), 64'(mq.size()));
        chk("desc_ready", 64'(dif.desc_ready), 64'(!abort && (mq.size() < DEPTH)));
        chk("irq", 64'(irq), 64'(irq_e));
        irq_e = (irq_e && !irq_clr) || de || ee;
        if (!enable) en_low = cyc;
        if (dif.desc_valid && dif.desc_ready) begin
          if (dif.desc_lines == '0) err_q.push_back(cyc + 1);
          else begin
            e.addr = dif.desc_start_addr; e.inc = dif.desc_addr_inc;
            e.bpl = dif.desc_bpl; e.lines = dif.desc_lines; e.acc = cyc;
            mq.push_back(e);
          end
        end
        if (abort) mq.delete();
      end
    end
  end

  // Autoreader emulator: issues the line requests, then drains its FIFO.
  // Completion is expected once all lines were requested, the settle
  // window ((1<<bpl)+2 cycles) has elapsed, and the FIFO reads empty.
  initial begin : autoreader
    int ln, s, r, e, dn;
    bit dead;
    rdr_mem_read_req = 1'b0;
    rdr_fifo_empty   = 1'b1;
    forever begin
      @(launched);
      ln = ar_lines; s = (1 << ar_bpl) + 2; dead = 1'b0; r = cyc;
      rdr_fifo_empty = 1'b0;
      for (int k = 0; k < ln && !dead; k++) begin
        repeat (slow_mode ? $urandom_range(2, 4) : $urandom_range(0, 2)) begin
          @(negedge clk);
          if (rst) dead = 1'b1;
        end
        if (!dead) begin
          rdr_mem_read_req = 1'b1;
          r = cyc;
          @(negedge clk);
          rdr_mem_read_req = 1'b0;
          if (rst) dead = 1'b1;
        end
      end
      rdr_mem_read_req = 1'b0;
      if (!dead) begin
        e = drain_mode ? r + s + 52 : r + int'($urandom_range(0, s + 6));
        if (e < cyc) e = cyc;
        dn = (r + s + 3 > e + 1) ? r + s + 3 : e + 1;
        done_q.push_back(dn);
        while (cyc < e && !dead) begin
          @(negedge clk);
          if (rst) dead = 1'b1;
        end
      end
      rdr_fifo_empty = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [3:0] i,
                      input logic [1:0] b, input logic [3:0] l);
    int n = 0;
    bit ok = 1'b0;
    dif.desc_valid = 1'b1; dif.desc_start_addr = a; dif.desc_addr_inc = i;
    dif.desc_bpl = b; dif.desc_lines = l;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = dif.desc_ready;
      @(posedge clk); #1;
      n++;
    end
    dif.desc_valid = 1'b0;
    chk("push_timeout", 64'(ok), 64'(1));
  endtask

  task automatic wait_launch();
    int n = 0;
    while (!inflight && n < 500) begin tick(1); n++; end
    chk("launch_timeout", 64'(inflight), 64'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mq.size() != 0 || inflight || done_q.size() != 0 || err_q.size() != 0)
           && n < 5000) begin
      tick(1); n++;
    end
    chk("idle_timeout", 64'(n < 5000), 64'(1));
    tick(3);
  endtask

  initial begin : stim
    rst = 1'b1; enable = 1'b0; abort = 1'b0; irq_clr = 1'b0;
    dif.desc_valid = 1'b0; dif.desc_start_addr = '0; dif.desc_addr_inc = '0;
    dif.desc_bpl = '0; dif.desc_lines = '0;
    slow_mode = 1'b0; drain_mode = 1'b0;
    tick(3); rst = 1'b0; tick(2);

    // single descriptor: data_struct 0x19, four settle cycles
    enable = 1'b1;
    push(16'h0100, 4'd2, 2'd1, 4'd3);
    wait_idle();

    // zero-line descriptor is rejected, then irq cleared
    push(16'h1234, 4'd1, 2'd0, 4'd0);
    tick(3);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0; tick(2);

    // fill the queue with launches disabled; a fifth offer is held
    enable = 1'b0;
    for (int k = 0; k < 4; k++)
      push(16'(16'h2000 + k * 16), 4'(k + 1), 2'(k), 4'(k + 2));
    dif.desc_valid = 1'b1; dif.desc_start_addr = 16'h3000; dif.desc_addr_inc = 4'd7;
    dif.desc_bpl = 2'd3; dif.desc_lines = 4'd1;
    tick(5);
    enable = 1'b1;
    push(16'h3000, 4'd7, 2'd3, 4'd1);
    wait_idle();

    // abort while the first of three is running
    enable = 1'b0; slow_mode = 1'b1;
    push(16'h4000, 4'd1, 2'd2, 4'd8);
    push(16'h4100, 4'd1, 2'd0, 4'd2);
    push(16'h4200, 4'd1, 2'd1, 4'd2);
    enable = 1'b1;
    wait_launch();
    tick(3);
    abort = 1'b1; tick(1); abort = 1'b0;
    wait_idle();
    slow_mode = 1'b0;

    // FIFO stays non-empty for 50 cycles after settling
    drain_mode = 1'b1;
    push(16'h5000, 4'd3, 2'd0, 4'd2);
    wait_idle();
    drain_mode = 1'b0;

    // reset in the middle of RUN with two queued
    enable = 1'b0; slow_mode = 1'b1;
    push(16'h6000, 4'd1, 2'd0, 4'd15);
    push(16'h6100, 4'd1, 2'd0, 4'd15);
    push(16'h6200, 4'd1, 2'd0, 4'd15);
    enable = 1'b1;
    wait_launch();
    tick(4);
    rst = 1'b1; tick(2); rst = 1'b0;
    slow_mode = 1'b0;
    tick(6);

    // random traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 7))
        0: begin enable = 1'b0; tick(int'($urandom_range(1, 8))); enable = 1'b1; end
        1: begin irq_clr = 1'b1; tick(1); irq_clr = 1'b0; end
        2: tick(int'($urandom_range(1, 10)));
        default: push(16'($urandom), 4'($urandom), 2'($urandom),
                      ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      endcase
    end
    enable = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
